// File: rtl/rtl_ack_resp_pkg.sv
// Shared constants and helpers for the req/ack responder.
// Holds the clog2 helper used for counter sizing and the configuration range check.
// No logic; imported by the buffer and the top level.
package rtl_ack_resp_pkg;

   localparam int DEPTH_MIN = 2;
   localparam int DEPTH_MAX = 16;

   // Smallest r with (1 << r) >= v; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Legal DEPTH range, counters wide enough to hold DEPTH, watchdog of at least 2 cycles.
   function automatic bit cfg_ok(input int depth, input int cntw, input int tmo);
      return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
             (cntw >= clog2(depth + 1)) && (tmo >= 2);
   endfunction

endpackage

// File: rtl/rtl_ack_resp_if.sv
// Bundle of the requester-facing req/ack/vld signals and the downstream valid/ready port.
// slave = the responder, master = whoever drives req/vld and consumes outdat.
// Pure wiring, no latency.
interface rtl_ack_resp_if #(
   parameter int WIDTH = 128,
   parameter int CNTW  = 5
);
   logic             req;
   logic [WIDTH-1:0] reqinfo;
   logic             ack;
   logic             vld;
   logic             reqen;
   logic             flush;
   logic             outvld;
   logic [WIDTH-1:0] outdat;
   logic             outrdy;
   logic [CNTW-1:0]  inflight;
   logic [CNTW-1:0]  buflen;
   logic             vlderr;
   logic             tmoerr;

   modport slave (
      input  req, reqinfo, vld, reqen, flush, outrdy,
      output ack, outvld, outdat, inflight, buflen, vlderr, tmoerr
   );

   modport master (
      output req, reqinfo, vld, reqen, flush, outrdy,
      input  ack, outvld, outdat, inflight, buflen, vlderr, tmoerr
   );
endinterface

// File: rtl/rtl_ack_resp_buf.sv
// DEPTH x WIDTH register FIFO with wrapping pointers (DEPTH need not be a power of 2).
// Write visible on dout the cycle after wr; dout/len/empty are pure registered state.
// Writes at full and reads at empty are ignored; flush clears pointers and overrides wr/rd.
module rtl_ack_resp_buf
   import rtl_ack_resp_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   parameter int CNTW  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic [CNTW-1:0]  len,
   output logic             empty
);
   localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   typedef logic [PW-1:0] ptr_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNTW-1:0]  len_q, len_d;
   logic             wr_en, rd_en;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_en = wr & ~flush & (len_q != CNTW'(DEPTH));
   assign rd_en = rd & ~flush & (len_q != '0);

   // Pointer and occupancy next state; flush wins over any write or read.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      len_d  = len_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         len_d  = '0;
      end else begin
         if (wr_en) wptr_d = ptr_inc(wptr_q);
         if (rd_en) rptr_d = ptr_inc(rptr_q);
         case ({wr_en, rd_en})
            2'b10:   len_d = len_q + 1'b1;
            2'b01:   len_d = len_q - 1'b1;
            default: len_d = len_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         len_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         len_q  <= len_d;
      end
   end

   // Storage; cleared on reset so the head word reads 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wptr_q] <= din;
      end
   end

   assign dout  = mem_q[rptr_q];
   assign len   = len_q;
   assign empty = (len_q == '0);

endmodule

// File: rtl/rtl_ack_resp.sv
// Req/ack responder: acks only while buflen+inflight < DEPTH, buffers returned words, drains valid/ready.
// ack is combinational from registered state and req/reqen/flush; data reaches outdat 1 cycle after vld.
// outrdy low stalls the buffer, which then starves acks; optional watchdog via RTL_ACK_RESP_TMO_EN.
module rtl_ack_resp
   import rtl_ack_resp_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   parameter int CNTW  = 5,
   parameter int TMO   = 64
) (
   input  logic          clk,
   input  logic          rst,
   rtl_ack_resp_if.slave bus
);
   localparam bit CFG_OK = cfg_ok(DEPTH, CNTW, TMO);

   generate
      if (!CFG_OK) begin : g_cfg_err
         $error("rtl_ack_resp: illegal DEPTH/CNTW/TMO combination");
      end
   endgenerate

   logic [CNTW-1:0] inflight_q, inflight_d;
   logic [CNTW-1:0] buflen;
   logic [CNTW:0]   credit_sum;
   logic            vlderr_q, vlderr_d;
   logic            ack, vld_acc, pop, empty, tmo_hit, tmoerr;

   // Reserved slots = words held + words still owed by the requester.
   assign credit_sum = {1'b0, buflen} + {1'b0, inflight_q};
   assign ack        = bus.req & bus.reqen & ~bus.flush & ~rst &
                       (credit_sum < (CNTW+1)'(DEPTH));
   // A vld only counts when it answers an outstanding ack.
   assign vld_acc    = bus.vld & (inflight_q != '0);
   assign pop        = ~empty & bus.outrdy;

`ifdef RTL_ACK_RESP_TMO_EN
   localparam int AW = clog2(TMO + 1);
   logic [AW-1:0] age_q, age_d;
   logic          tmoerr_q, tmoerr_d;

   // Expiry returns one credit; a vld in the same cycle takes precedence so inflight cannot underflow.
   assign tmo_hit = (inflight_q != '0) & ~vld_acc & (age_q == AW'(TMO - 1));

   // Age of the oldest outstanding ack, restarted on first ack, each accepted vld and each expiry.
   always_comb begin
      age_d    = age_q + 1'b1;
      tmoerr_d = tmoerr_q | tmo_hit;
      if (inflight_d == '0)
         age_d = '0;
      else if ((inflight_q == '0) || vld_acc || tmo_hit)
         age_d = AW'(1);
   end

   // Watchdog registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_q    <= '0;
         tmoerr_q <= 1'b0;
      end else begin
         age_q    <= age_d;
         tmoerr_q <= tmoerr_d;
      end
   end

   assign tmoerr = tmoerr_q;
`else
   assign tmo_hit = 1'b0;
   assign tmoerr  = 1'b0;
`endif

   // Credit accounting and sticky spurious-vld flag; flush leaves inflight alone.
   always_comb begin
      inflight_d = inflight_q + {{(CNTW-1){1'b0}}, ack}
                              - {{(CNTW-1){1'b0}}, vld_acc}
                              - {{(CNTW-1){1'b0}}, tmo_hit};
      vlderr_d   = vlderr_q | (bus.vld & (inflight_q == '0));
   end

   // Credit and error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
         vlderr_q   <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         vlderr_q   <= vlderr_d;
      end
   end

   rtl_ack_resp_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNTW  (CNTW)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .wr    (vld_acc),
      .din   (bus.reqinfo),
      .rd    (pop),
      .flush (bus.flush),
      .dout  (bus.outdat),
      .len   (buflen),
      .empty (empty)
   );

   assign bus.ack      = ack;
   assign bus.outvld   = ~empty;
   assign bus.inflight = inflight_q;
   assign bus.buflen   = buflen;
   assign bus.vlderr   = vlderr_q;
   assign bus.tmoerr   = tmoerr;

endmodule

// File: tb/tb_rtl_ack_resp.sv
// Bench for rtl_ack_resp: cycle table for the directed scenarios, then reset, random and watchdog sequences.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// A data scoreboard pairs every accepted vld word with the word popped downstream.
module tb_rtl_ack_resp;
   localparam int W = 128;
   localparam int D = 4;
   localparam int CW = 5;
   localparam int T = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rtl_ack_resp_if #(.WIDTH(W), .CNTW(CW)) bus ();

   rtl_ack_resp #(.WIDTH(W), .DEPTH(D), .CNTW(CW), .TMO(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        req, reqen, flush, vld, outrdy;
      logic [15:0] din;
      int          ack, ov, bl, inf, ve;
   } vec_t;
   vec_t tv[$];

   task automatic chki(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic chkd(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Pop side of the scoreboard: called at negedge when the DUT hands a word over.
   task automatic sb_pop(input string nm);
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL %s: got %0h expected no word", nm, bus.outdat);
      end else begin
         chkd(nm, bus.outdat, exp_q.pop_front());
      end
   endtask

   task automatic row(input logic rq, input logic re, input logic fl, input logic v,
                      input logic ordy, input logic [15:0] d,
                      input int a, input int ov, input int bl, input int inf, input int ve);
      vec_t r;
      r.req = rq; r.reqen = re; r.flush = fl; r.vld = v; r.outrdy = ordy; r.din = d;
      r.ack = a; r.ov = ov; r.bl = bl; r.inf = inf; r.ve = ve;
      tv.push_back(r);
   endtask

   task automatic idle_inputs();
      bus.req = 1'b0; bus.reqen = 1'b1; bus.flush = 1'b0;
      bus.vld = 1'b0; bus.outrdy = 1'b0; bus.reqinfo = '0;
   endtask

   initial begin
      int pending;
      int m_if;
      int eack;

      //   req re fl vld rdy din       ack ov bl if ve
      row(1, 1, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 0);   // fill: 4 acks, latency-1 vlds
      row(1, 1, 0, 1, 0, 16'h0011,   1, 0, 0, 1, 0);
      row(1, 1, 0, 1, 0, 16'h0022,   1, 1, 1, 1, 0);
      row(1, 1, 0, 1, 0, 16'h0033,   1, 1, 2, 1, 0);
      row(1, 1, 0, 1, 0, 16'h0044,   0, 1, 3, 1, 0);   // credit exhausted
      row(1, 1, 0, 0, 0, 16'h0000,   0, 1, 4, 0, 0);
      row(1, 1, 0, 0, 1, 16'h0000,   0, 1, 4, 0, 0);   // drain 11
      row(1, 1, 0, 0, 1, 16'h0000,   1, 1, 3, 0, 0);   // ack returns after first pop
      row(0, 1, 0, 1, 1, 16'h0055,   0, 1, 2, 1, 0);   // pop 33 + write 55
      row(0, 1, 0, 0, 1, 16'h0000,   0, 1, 2, 0, 0);
      row(0, 1, 0, 0, 1, 16'h0000,   0, 1, 1, 0, 0);
      row(0, 1, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 0);
      row(0, 1, 0, 1, 0, 16'hDEAD,   0, 0, 0, 0, 0);   // spurious vld
      row(0, 1, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 1);
      row(1, 1, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 1);   // refill to credit limit, wptr wraps
      row(1, 1, 0, 1, 0, 16'h0061,   1, 0, 0, 1, 1);
      row(1, 1, 0, 1, 0, 16'h0062,   1, 1, 1, 1, 1);
      row(1, 1, 0, 1, 0, 16'h0063,   1, 1, 2, 1, 1);
      row(0, 1, 0, 1, 1, 16'h0064,   0, 1, 3, 1, 1);   // write+pop at credit-full
      row(0, 1, 0, 0, 1, 16'h0000,   0, 1, 3, 0, 1);
      row(1, 1, 0, 0, 1, 16'h0000,   1, 1, 2, 0, 1);
      row(0, 1, 0, 1, 1, 16'h0065,   0, 1, 1, 1, 1);   // write+pop at buflen 1
      row(0, 1, 0, 0, 1, 16'h0000,   0, 1, 1, 0, 1);
      row(0, 1, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 1);
      row(1, 1, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 1);   // buflen 2, inflight 1, then flush
      row(1, 1, 0, 1, 0, 16'h0071,   1, 0, 0, 1, 1);
      row(1, 1, 0, 1, 0, 16'h0072,   1, 1, 1, 1, 1);
      row(1, 1, 1, 0, 0, 16'h0000,   0, 1, 2, 1, 1);   // flush suppresses ack
      row(0, 1, 0, 0, 0, 16'h0000,   0, 0, 0, 1, 1);
      row(0, 1, 0, 1, 0, 16'h0073,   0, 0, 0, 1, 1);   // late vld stored after flush
      row(0, 1, 0, 0, 0, 16'h0000,   0, 1, 1, 0, 1);
      row(0, 1, 0, 0, 1, 16'h0000,   0, 1, 1, 0, 1);
      row(1, 0, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 1);   // reqen low blocks ack
      row(1, 1, 0, 0, 0, 16'h0000,   1, 0, 0, 0, 1);
      row(0, 1, 0, 1, 1, 16'h0074,   0, 0, 0, 1, 1);
      row(0, 1, 0, 0, 1, 16'h0000,   0, 1, 1, 0, 1);
      row(0, 1, 0, 0, 0, 16'h0000,   0, 0, 0, 0, 1);

      // Reset state, with req/reqen high to show ack is held off.
      idle_inputs();
      bus.req = 1'b1;
      #12;
      chki("rst ack", int'(bus.ack), 0);
      chki("rst outvld", int'(bus.outvld), 0);
      chkd("rst outdat", bus.outdat, '0);
      chki("rst inflight", int'(bus.inflight), 0);
      chki("rst buflen", int'(bus.buflen), 0);
      chki("rst vlderr", int'(bus.vlderr), 0);
      chki("rst tmoerr", int'(bus.tmoerr), 0);
      bus.req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk); #1;
         bus.req = tv[i].req; bus.reqen = tv[i].reqen; bus.flush = tv[i].flush;
         bus.vld = tv[i].vld; bus.outrdy = tv[i].outrdy;
         bus.reqinfo = {{(W-16){1'b0}}, tv[i].din};
         @(negedge clk);
         chki($sformatf("r%0d ack", i), int'(bus.ack), tv[i].ack);
         chki($sformatf("r%0d outvld", i), int'(bus.outvld), tv[i].ov);
         chki($sformatf("r%0d buflen", i), int'(bus.buflen), tv[i].bl);
         chki($sformatf("r%0d inflight", i), int'(bus.inflight), tv[i].inf);
         chki($sformatf("r%0d vlderr", i), int'(bus.vlderr), tv[i].ve);
         if (tv[i].flush) begin
            exp_q.delete();
         end else begin
            if (bus.outvld && bus.outrdy) sb_pop($sformatf("r%0d outdat", i));
            if (tv[i].vld && tv[i].inf != 0) exp_q.push_back({{(W-16){1'b0}}, tv[i].din});
         end
      end
      chki("table sb empty", exp_q.size(), 0);

      // Asynchronous reset with one word buffered and one ack outstanding.
      @(posedge clk); #1;
      idle_inputs(); bus.req = 1'b1;
      @(negedge clk);
      chki("ar ack0", int'(bus.ack), 1);
      @(posedge clk); #1;
      bus.vld = 1'b1; bus.reqinfo = W'(128'h81);
      @(posedge clk); #1;
      bus.vld = 1'b0;
      chki("ar buflen pre", int'(bus.buflen), 1);
      chki("ar inflight pre", int'(bus.inflight), 1);
      #2 rst = 1'b1;
      #1;
      chki("ar ack", int'(bus.ack), 0);
      chki("ar buflen", int'(bus.buflen), 0);
      chki("ar inflight", int'(bus.inflight), 0);
      chki("ar outvld", int'(bus.outvld), 0);
      chki("ar vlderr", int'(bus.vlderr), 0);
      chkd("ar outdat", bus.outdat, '0);
      bus.req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      bus.vld = 1'b1; bus.reqinfo = W'(128'h82);
      @(posedge clk); #1;
      bus.vld = 1'b0;
      chki("ar late vlderr", int'(bus.vlderr), 1);
      chki("ar late buflen", int'(bus.buflen), 0);

      // Random traffic: in-order requester with random answer delay, random downstream stalls.
      exp_q.delete();
      pending = 0;
      m_if = 0;
      for (int c = 0; c < 420; c++) begin
         @(posedge clk); #1;
         bus.req    = (c < 400) && ($urandom_range(0, 3) != 0);
         bus.reqen  = ($urandom_range(0, 7) != 0);
         bus.outrdy = (c >= 400) || ($urandom_range(0, 1) != 0);
         bus.flush  = 1'b0;
         if (pending > 0 && $urandom_range(0, 2) != 0) begin
            bus.vld = 1'b1;
            bus.reqinfo = {$urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            bus.vld = 1'b0;
         end
         @(negedge clk);
         eack = (bus.req && bus.reqen && (exp_q.size() + m_if < D)) ? 1 : 0;
         chki($sformatf("rnd%0d ack", c), int'(bus.ack), eack);
         chki($sformatf("rnd%0d inflight", c), int'(bus.inflight), m_if);
         chki($sformatf("rnd%0d buflen", c), int'(bus.buflen), exp_q.size());
         if (bus.outvld && bus.outrdy) sb_pop($sformatf("rnd%0d outdat", c));
         if (bus.vld) begin
            exp_q.push_back(bus.reqinfo);
            pending--;
            m_if--;
         end
         if (eack != 0) begin
            pending++;
            m_if++;
         end
      end
      chki("rnd sb empty", exp_q.size(), 0);
      chki("rnd vlderr", int'(bus.vlderr), 1);

`ifdef RTL_ACK_RESP_TMO_EN
      // Watchdog: one ack never answered.
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk); #1;
      bus.req = 1'b1;
      @(negedge clk);
      chki("tmo ack", int'(bus.ack), 1);
      for (int k = 1; k <= T; k++) begin
         @(posedge clk); #1;
         bus.req = 1'b0;
         if (k == T - 1) begin
            chki("tmo err early", int'(bus.tmoerr), 0);
            chki("tmo inflight early", int'(bus.inflight), 1);
         end
         if (k == T) begin
            chki("tmo err", int'(bus.tmoerr), 1);
            chki("tmo inflight", int'(bus.inflight), 0);
         end
      end
      bus.vld = 1'b1; bus.reqinfo = W'(128'h99);
      @(posedge clk); #1;
      bus.vld = 1'b0;
      chki("tmo late vlderr", int'(bus.vlderr), 1);
      chki("tmo late buflen", int'(bus.buflen), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
